// File: rtl/call_request_scheduler.sv
// Hall-call front end for the four-floor elevator: synchronises and debounces the raw
// buttons, latches pending calls and runs a SCAN scheduler that hands at most one
// floor request, one-hot, to the elevator state machine.
module call_request_scheduler #(
  parameter int unsigned DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] btn_raw,
  input  logic [1:0] cur_floor,
  output logic [3:0] req_onehot,
  output logic [3:0] pending,
  output logic       dir_up,
  output logic       busy
);

  localparam int unsigned CntW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StUp   = 2'b01,
    StDown = 2'b10
  } sched_state_e;

  // Synchroniser and debouncer state, one lane per button.
  logic [3:0]      s1_q, s2_q;
  logic [3:0]      db_q, db_d;
  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  logic [3:0]   pending_q, pending_d;
  logic [3:0]   db_rise;
  logic [3:0]   clr_mask;

  sched_state_e state_q, state_d;
  logic [3:0]   req_q, req_d;

  logic [3:0]   cur_onehot;
  logic [3:0]   above, below;
  logic [3:0]   near_above, near_below;

  // Two-flop synchroniser on every raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 4'b0000;
      s2_q <= 4'b0000;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce: the level must disagree with db for DB_CYCLES consecutive samples.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        db_d[i]  = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  // Debounced level and per-button stability counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      db_q <= db_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // A call registers on the debounced rising edge; set beats a same-edge clear.
  always_comb begin
    cur_onehot = 4'b0001 << cur_floor;
    db_rise    = db_d & ~db_q;
    clr_mask   = tick ? cur_onehot : 4'b0000;
    pending_d  = (pending_q & ~clr_mask) | db_rise;
  end

  // Latched outstanding calls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 4'b0000;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Split pending calls around the car and pick the nearest in each direction.
  always_comb begin
    above      = 4'b0000;
    below      = 4'b0000;
    near_above = 4'b0000;
    near_below = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(cur_floor)) begin
        above[i] = pending_q[i];
      end
      if (i < int'(cur_floor)) begin
        below[i] = pending_q[i];
      end
    end
    // Nearest above is the lowest set bit, so scan downwards and keep the last hit.
    for (int i = 3; i >= 0; i--) begin
      if (above[i]) begin
        near_above = 4'b0001 << i;
      end
    end
    // Nearest below is the highest set bit, so scan upwards and keep the last hit.
    for (int i = 0; i < 4; i++) begin
      if (below[i]) begin
        near_below = 4'b0001 << i;
      end
    end
  end

  // SCAN next state; the request always matches the state being entered.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StUp: begin
        if (|above) begin
          state_d = StUp;
        end else if (|below) begin
          state_d = StDown;
        end else begin
          state_d = StIdle;
        end
      end
      StDown: begin
        if (|below) begin
          state_d = StDown;
        end else if (|above) begin
          state_d = StUp;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        if (|above) begin
          state_d = StUp;
        end else if (|below) begin
          state_d = StDown;
        end else begin
          state_d = StIdle;
        end
      end
    endcase

    unique case (state_d)
      StUp:    req_d = near_above;
      StDown:  req_d = near_below;
      default: req_d = pending_q & cur_onehot;
    endcase
  end

  // Scheduler state and registered request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
    end
  end

  assign req_onehot = req_q;
  assign pending    = pending_q;
  assign dir_up     = (state_q == StUp);
  assign busy       = |pending_q;

endmodule

// File: tb/tb_call_request_scheduler.sv
// Directed bench for call_request_scheduler with a short debounce (DB_CYCLES = 4).
module tb_call_request_scheduler;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] btn_raw;
  logic [1:0] cur_floor;
  logic [3:0] req_onehot;
  logic [3:0] pending;
  logic       dir_up;
  logic       busy;

  int unsigned n_vec;
  int unsigned n_bad;

  call_request_scheduler #(
    .DB_CYCLES(4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_raw   (btn_raw),
    .cur_floor (cur_floor),
    .req_onehot(req_onehot),
    .pending   (pending),
    .dir_up    (dir_up),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    edges(1);
    tick = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    tick      = 1'b0;
    btn_raw   = 4'b0000;
    cur_floor = 2'b00;
    edges(2);
    check("reset_req", req_onehot, 4'b0000);
    check("reset_pending", pending, 4'b0000);
    check("reset_dir", {3'b000, dir_up}, 4'b0000);
    check("reset_busy", {3'b000, busy}, 4'b0000);
    rst = 1'b0;

    // Debounce: a 3-cycle pulse is rejected, a held press lands at edge 6.
    btn_raw = 4'b0100;
    edges(3);
    btn_raw = 4'b0000;
    edges(6);
    check("glitch_pending", pending, 4'b0000);
    btn_raw = 4'b0100;
    edges(5);
    check("press_e5_pending", pending, 4'b0000);
    edges(1);
    check("press_e6_pending", pending, 4'b0100);
    check("press_e6_req", req_onehot, 4'b0000);
    edges(1);
    check("press_e7_req", req_onehot, 4'b0100);
    check("press_e7_dir", {3'b000, dir_up}, 4'b0001);
    check("press_e7_busy", {3'b000, busy}, 4'b0001);

    // SCAN sweep from floor 1 with calls at 0, 2, 3.
    btn_raw   = 4'b1001;
    cur_floor = 2'b01;
    edges(7);
    btn_raw = 4'b0000;
    check("scan_pending", pending, 4'b1101);
    check("scan_req", req_onehot, 4'b0100);
    check("scan_dir", {3'b000, dir_up}, 4'b0001);
    cur_floor = 2'b10;
    tick_once();
    check("scan_f2_pending", pending, 4'b1001);
    edges(1);
    check("scan_f2_req", req_onehot, 4'b1000);
    check("scan_f2_dir", {3'b000, dir_up}, 4'b0001);
    cur_floor = 2'b11;
    tick_once();
    check("scan_f3_pending", pending, 4'b0001);
    edges(1);
    check("scan_f3_req", req_onehot, 4'b0001);
    check("scan_f3_dir", {3'b000, dir_up}, 4'b0000);
    cur_floor = 2'b00;
    tick_once();
    check("scan_f0_pending", pending, 4'b0000);
    edges(1);
    check("scan_f0_req", req_onehot, 4'b0000);
    check("scan_f0_busy", {3'b000, busy}, 4'b0000);

    // Idle call at the current floor.
    cur_floor = 2'b10;
    btn_raw   = 4'b0100;
    edges(6);
    check("idle_pending", pending, 4'b0100);
    edges(1);
    check("idle_req", req_onehot, 4'b0100);
    check("idle_dir", {3'b000, dir_up}, 4'b0000);
    check("idle_busy", {3'b000, busy}, 4'b0001);
    btn_raw = 4'b0000;
    edges(8);
    tick_once();
    check("idle_clr_pending", pending, 4'b0000);
    check("idle_clr_req_hold", req_onehot, 4'b0100);
    edges(1);
    check("idle_clr_req", req_onehot, 4'b0000);

    // Set and clear on the same edge: set wins.
    cur_floor = 2'b01;
    btn_raw   = 4'b0010;
    edges(5);
    check("coll_e5_pending", pending, 4'b0000);
    tick = 1'b1;
    edges(1);
    tick = 1'b0;
    check("coll_pending", pending, 4'b0010);
    edges(1);
    check("coll_req", req_onehot, 4'b0010);
    btn_raw = 4'b0000;
    edges(8);
    tick_once();
    check("coll_clr_pending", pending, 4'b0000);
    edges(1);
    check("coll_clr_req", req_onehot, 4'b0000);

    // Reversal at the top floor, then a new top call while sweeping down.
    cur_floor = 2'b10;
    btn_raw   = 4'b1000;
    edges(7);
    check("rev_up_pending", pending, 4'b1000);
    check("rev_up_req", req_onehot, 4'b1000);
    check("rev_up_dir", {3'b000, dir_up}, 4'b0001);
    btn_raw = 4'b0001;
    edges(7);
    check("rev_both_pending", pending, 4'b1001);
    check("rev_both_req", req_onehot, 4'b1000);
    btn_raw = 4'b0000;
    edges(8);
    cur_floor = 2'b11;
    tick_once();
    check("rev_top_pending", pending, 4'b0001);
    edges(1);
    check("rev_down_req", req_onehot, 4'b0001);
    check("rev_down_dir", {3'b000, dir_up}, 4'b0000);
    btn_raw = 4'b1000;
    edges(7);
    check("rev_add_pending", pending, 4'b1001);
    check("rev_add_req", req_onehot, 4'b0001);
    check("rev_add_dir", {3'b000, dir_up}, 4'b0000);

    // Reset mid-run with L3 held through release.
    btn_raw = 4'b1010;
    edges(7);
    check("mid_pending", pending, 4'b1011);
    check("mid_req_nearest_below", req_onehot, 4'b0010);
    #2;
    rst  = 1'b1;
    tick = 1'b1;
    #1;
    check("mid_rst_req", req_onehot, 4'b0000);
    check("mid_rst_pending", pending, 4'b0000);
    check("mid_rst_dir", {3'b000, dir_up}, 4'b0000);
    check("mid_rst_busy", {3'b000, busy}, 4'b0000);
    btn_raw = 4'b1000;
    edges(2);
    tick = 1'b0;
    check("mid_rst_hold_pending", pending, 4'b0000);
    rst = 1'b0;
    edges(5);
    check("rel_e5_pending", pending, 4'b0000);
    edges(1);
    check("rel_e6_pending", pending, 4'b1000);
    edges(1);
    check("rel_e7_req", req_onehot, 4'b1000);
    check("rel_e7_dir", {3'b000, dir_up}, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
